// File: rtl/char_vertical_ctrl.sv
// char_vertical_ctrl: vertical motion of the player character.
// Latches spring contact and jump-button requests while grounded and integrates
// velocity and gravity once per physics tick, producing the absolute char_Y.
// Optional feature macro: VARIABLE_JUMP_EN. When it is defined, releasing the
// button early during a button jump caps the upward speed at JUMP_CUT_V.
module char_vertical_ctrl #(
    parameter logic [8:0]  CHAR_SIZE = 9'd16,
    parameter logic [8:0]  START_Y   = 9'd100,
    parameter logic [19:0] TICK_DIV  = 20'd833333,
    parameter logic [5:0]  JUMP_V    = 6'd6,
    parameter logic [5:0]  SPRING_V  = 6'd10,
    parameter logic [5:0]  GRAVITY   = 6'd1,
    parameter logic [5:0]  MAX_FALL  = 6'd8
`ifdef VARIABLE_JUMP_EN
    ,
    parameter logic [5:0]  JUMP_CUT_V = 6'd2
`endif
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       btn_jump,
    input  logic       spring_jump,
    input  logic [8:0] floor_Y,
    output logic [8:0] char_Y,
    output logic [5:0] vel_Y,
    output logic       airborne,
    output logic       landed
);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } state_t;

    state_t      r_state;
    logic [19:0] r_tick_cnt;
    logic        r_btn_d;
    logic        r_btn_pend;
    logic        r_spring_pend;
    logic [8:0]  r_char_y;
    logic [5:0]  r_vel_y;
    logic        r_airborne;
    logic        r_landed;
`ifdef VARIABLE_JUMP_EN
    logic        r_from_btn;
`endif

    logic        w_tick;
    logic        w_btn_rise;
    logic [5:0]  w_vel_eff;
    logic [9:0]  w_next;
    logic [5:0]  w_vel_inc;
    logic [5:0]  w_fall_vel;
    logic [8:0]  w_land_y;
    logic        w_above_floor;
    logic        w_hit_floor;

    assign w_tick     = (r_tick_cnt == (TICK_DIV - 20'd1));
    assign w_btn_rise = btn_jump & ~r_btn_d;

    // Physics tick divider: one tick cycle every TICK_DIV clocks
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 20'd1;
        end
    end

    // Request latches: only armed while grounded, always cleared by a tick
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_btn_d       <= 1'b0;
            r_btn_pend    <= 1'b0;
            r_spring_pend <= 1'b0;
        end else begin
            r_btn_d <= btn_jump;
            if (w_tick || (r_state != ST_GROUND)) begin
                r_btn_pend    <= 1'b0;
                r_spring_pend <= 1'b0;
            end else begin
                if (w_btn_rise)  r_btn_pend    <= 1'b1;
                if (spring_jump) r_spring_pend <= 1'b1;
            end
        end
    end

    // Effective velocity for this tick (early-release cut when enabled)
    always_comb begin
        w_vel_eff = r_vel_y;
`ifdef VARIABLE_JUMP_EN
        if ((r_state == ST_RISE) && r_from_btn && !btn_jump &&
            ($signed(r_vel_y) < $signed(6'd0 - JUMP_CUT_V))) begin
            w_vel_eff = 6'd0 - JUMP_CUT_V;
        end
`endif
    end

    // Position/velocity arithmetic shared by the motion states
    assign w_next        = {1'b0, r_char_y} + {{4{w_vel_eff[5]}}, w_vel_eff};
    assign w_vel_inc     = w_vel_eff + GRAVITY;
    assign w_fall_vel    = ($signed(w_vel_inc) > $signed(MAX_FALL)) ? MAX_FALL : w_vel_inc;
    assign w_land_y      = floor_Y - CHAR_SIZE;
    assign w_above_floor = (({2'b0, r_char_y} + {2'b0, CHAR_SIZE}) < {2'b0, floor_Y});
    assign w_hit_floor   = (({1'b0, w_next} + {2'b0, CHAR_SIZE}) >= {2'b0, floor_Y});

    // Motion FSM: all state and outputs update on tick cycles only
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= ST_FALL;
            r_char_y   <= START_Y;
            r_vel_y    <= '0;
            r_airborne <= 1'b1;
            r_landed   <= 1'b0;
`ifdef VARIABLE_JUMP_EN
            r_from_btn <= 1'b0;
`endif
        end else begin
            r_landed <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_GROUND: begin
                        if (r_spring_pend) begin
                            r_vel_y    <= 6'd0 - SPRING_V;
                            r_state    <= ST_RISE;
                            r_airborne <= 1'b1;
`ifdef VARIABLE_JUMP_EN
                            r_from_btn <= 1'b0;
`endif
                        end else if (r_btn_pend) begin
                            r_vel_y    <= 6'd0 - JUMP_V;
                            r_state    <= ST_RISE;
                            r_airborne <= 1'b1;
`ifdef VARIABLE_JUMP_EN
                            r_from_btn <= 1'b1;
`endif
                        end else if (w_above_floor) begin
                            r_vel_y    <= '0;
                            r_state    <= ST_FALL;
                            r_airborne <= 1'b1;
                        end else begin
                            r_char_y <= w_land_y;
                        end
                    end
                    ST_RISE: begin
                        if (w_next[9]) begin
                            r_char_y <= '0;
                            r_vel_y  <= '0;
                            r_state  <= ST_FALL;
                        end else begin
                            r_char_y <= w_next[8:0];
                            r_vel_y  <= w_vel_inc;
                            if (!w_vel_inc[5]) r_state <= ST_FALL;
                        end
                    end
                    ST_FALL: begin
                        if (w_hit_floor) begin
                            r_char_y   <= w_land_y;
                            r_vel_y    <= '0;
                            r_state    <= ST_GROUND;
                            r_airborne <= 1'b0;
                            r_landed   <= 1'b1;
                        end else begin
                            r_char_y <= w_next[8:0];
                            r_vel_y  <= w_fall_vel;
                        end
                    end
                    default: begin
                        r_state    <= ST_FALL;
                        r_airborne <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign char_Y   = r_char_y;
    assign vel_Y    = r_vel_y;
    assign airborne = r_airborne;
    assign landed   = r_landed;

endmodule

// File: tb/tb_char_vertical_ctrl.sv
// Directed scoreboard bench for char_vertical_ctrl with a 4-cycle physics tick.
module tb_char_vertical_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       btn_jump;
    logic       spring_jump;
    logic [8:0] floor_Y;
    logic [8:0] char_Y;
    logic [5:0] vel_Y;
    logic       airborne;
    logic       landed;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string tag;
        int    y;
        int    v;
        bit    air;
        bit    land;
    } exp_t;

    exp_t sb[$];

    // Fall from reset onto floor 200, one entry per tick
    int f1_y[14] = '{100, 101, 103, 106, 110, 115, 121, 128, 136, 144, 152, 160, 168, 176};
    int f1_v[14] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8, 8, 8, 8, 8};
    // Button jump arc after the launch tick
    int j1_y[12] = '{178, 173, 169, 166, 164, 163, 163, 164, 166, 169, 173, 178};
    int j1_v[12] = '{-5, -4, -3, -2, -1, 0, 1, 2, 3, 4, 5, 6};
    // Drop from 184 to floor 240 after the floor moves away
    int f2_y[9]  = '{184, 185, 187, 190, 194, 199, 205, 212, 220};
    int f2_v[9]  = '{1, 2, 3, 4, 5, 6, 7, 8, 8};

    char_vertical_ctrl #(
        .TICK_DIV (20'd4)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .btn_jump    (btn_jump),
        .spring_jump (spring_jump),
        .floor_Y     (floor_Y),
        .char_Y      (char_Y),
        .vel_Y       (vel_Y),
        .airborne    (airborne),
        .landed      (landed)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input string tag, input int y, input int v, input bit air, input bit land);
        exp_t e;
        e.tag  = tag;
        e.y    = y;
        e.v    = v;
        e.air  = air;
        e.land = land;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty got size 0 exp >0");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (char_Y === 9'(e.y)) else begin
                errors++;
                $error("FAIL %s char_Y got %0d exp %0d", e.tag, char_Y, e.y);
            end
            checks++;
            assert (vel_Y === 6'(e.v)) else begin
                errors++;
                $error("FAIL %s vel_Y got %0d exp %0d", e.tag, $signed(vel_Y), e.v);
            end
            checks++;
            assert (airborne === e.air) else begin
                errors++;
                $error("FAIL %s airborne got %0b exp %0b", e.tag, airborne, e.air);
            end
            checks++;
            assert (landed === e.land) else begin
                errors++;
                $error("FAIL %s landed got %0b exp %0b", e.tag, landed, e.land);
            end
        end
    endtask

    task automatic tick_exp(input string tag, input int y, input int v, input bit air, input bit land);
        push(tag, y, v, air, land);
        step(4);
        pop_check();
    endtask

    task automatic wait_land(input string tag, input int exp_y, input int budget);
        bit seen;
        seen = 1'b0;
        push(tag, exp_y, 0, 1'b0, 1'b1);
        for (int i = 0; i < budget; i++) begin
            step(4);
            if (landed === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        assert (seen === 1'b1) else begin
            errors++;
            $error("FAIL %s landing got none exp within %0d ticks", tag, budget);
        end
        pop_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n   = 1'b0;
        btn_jump    = 1'b0;
        spring_jump = 1'b0;
        floor_Y     = 9'd200;
        step(2);
        push("reset", 100, 0, 1'b1, 1'b0);
        pop_check();
        sys_rst_n = 1'b1;

        // Fall from reset and land at 184
        for (int i = 0; i < 14; i++) tick_exp("fall1", f1_y[i], f1_v[i], 1'b1, 1'b0);
        tick_exp("land1", 184, 0, 1'b0, 1'b1);
        tick_exp("ground1", 184, 0, 1'b0, 1'b0);

        // Button jump arc
        btn_jump = 1'b1;
        tick_exp("btn_launch", 184, -6, 1'b1, 1'b0);
        btn_jump = 1'b0;
        for (int i = 0; i < 12; i++) tick_exp("btn_arc", j1_y[i], j1_v[i], 1'b1, 1'b0);
        tick_exp("land2", 184, 0, 1'b0, 1'b1);

        // Spring and button in the same cycle: spring wins
        spring_jump = 1'b1;
        btn_jump    = 1'b1;
        step(1);
        spring_jump = 1'b0;
        push("spring_win", 184, -10, 1'b1, 1'b0);
        step(3);
        pop_check();
        tick_exp("spring_first", 174, -9, 1'b1, 1'b0);
        btn_jump = 1'b0;
        wait_land("spring_land", 184, 30);

        // Floor drops away to 240, terminal velocity cap
        floor_Y = 9'd240;
        tick_exp("floor_drop", 184, 0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) tick_exp("fall240", f2_y[i], f2_v[i], 1'b1, 1'b0);
        tick_exp("land240", 224, 0, 1'b0, 1'b1);

        // Low floor, spring into the ceiling clamp
        floor_Y = 9'd20;
        tick_exp("snap4", 4, 0, 1'b0, 1'b0);
        spring_jump = 1'b1;
        step(1);
        spring_jump = 1'b0;
        push("ceil_launch", 4, -10, 1'b1, 1'b0);
        step(3);
        pop_check();
        tick_exp("ceil_clamp", 0, 0, 1'b1, 1'b0);
        tick_exp("ceil_f1", 0, 1, 1'b1, 1'b0);
        tick_exp("ceil_f2", 1, 2, 1'b1, 1'b0);
        tick_exp("ceil_f3", 3, 3, 1'b1, 1'b0);
        tick_exp("ceil_land", 4, 0, 1'b0, 1'b1);

        // Back to floor 200, then reset mid-rise
        floor_Y = 9'd200;
        tick_exp("drop200", 4, 0, 1'b1, 1'b0);
        wait_land("land_from4", 184, 40);
        btn_jump = 1'b1;
        tick_exp("rise_launch", 184, -6, 1'b1, 1'b0);
        btn_jump = 1'b0;
        tick_exp("rise_1", 178, -5, 1'b1, 1'b0);
        btn_jump = 1'b1;
        step(1);
        btn_jump  = 1'b0;
        sys_rst_n = 1'b0;
        step(2);
        push("reset_midrise", 100, 0, 1'b1, 1'b0);
        pop_check();
        sys_rst_n = 1'b1;
        tick_exp("post_rst", 100, 1, 1'b1, 1'b0);
        wait_land("land_post_rst", 184, 30);

        // Pending button request killed by reset before its tick
        btn_jump = 1'b1;
        step(1);
        sys_rst_n = 1'b0;
        step(2);
        btn_jump  = 1'b0;
        sys_rst_n = 1'b1;
        push("reset_stale", 100, 0, 1'b1, 1'b0);
        pop_check();
        tick_exp("no_stale", 100, 1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
